// File: rtl/elevator_pkg.sv
// elevator_pkg: shared FSM state encoding for the elevator controller
package elevator_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, UP = 2'd1, DOWN = 2'd2, DOOR = 2'd3} state_t;
endpackage

// File: rtl/elevator_ctrl_if.sv
// elevator_ctrl_if: call-button inputs and car/door/display outputs of the controller
interface elevator_ctrl_if #(
  parameter int FLOORS  = 8,
  parameter int FLOOR_W = $clog2(FLOORS)
) ();
  import elevator_pkg::*;
  logic [FLOORS-1:0]  call_req;
  logic [FLOOR_W-1:0] floor;
  logic               dir_up;
  logic               moving;
  logic               door_open;
  logic [FLOORS-1:0]  pending;
  state_t             state;
  modport master (input call_req, output floor, dir_up, moving, door_open, pending, state);
  modport slave  (output call_req, input floor, dir_up, moving, door_open, pending, state);
endinterface

// File: rtl/elevator_ctrl_req_scan.sv
// req_scan: flags outstanding calls above, below and at a given floor
module req_scan #(
  parameter int FLOORS  = 8,
  parameter int FLOOR_W = $clog2(FLOORS)
) (
  input  logic [FLOORS-1:0]  pend,
  input  logic [FLOOR_W-1:0] floor,
  output logic               above,
  output logic               below,
  output logic               here
);
  // OR-reduce the call vector on each side of the floor
  always_comb begin
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      above = above | (pend[i] & (i > int'(floor)));
      below = below | (pend[i] & (i < int'(floor)));
    end
    here = pend[floor];
  end
endmodule

// File: rtl/elevator_ctrl.sv
// elevator_ctrl: SCAN-order elevator controller with travel and door dwell timers
module elevator_ctrl
  import elevator_pkg::*;
#(
  parameter int FLOORS      = 8,
  parameter int MOVE_CYCLES = 4,
  parameter int DOOR_CYCLES = 6
) (
  input logic clk,
  input logic rst,
  elevator_ctrl_if.master bus
);
  localparam int FLOOR_W = $clog2(FLOORS);
  localparam int MW = MOVE_CYCLES > 1 ? $clog2(MOVE_CYCLES) : 1;
  localparam int DW = DOOR_CYCLES > 1 ? $clog2(DOOR_CYCLES) : 1;
  state_t             state;
  logic [FLOOR_W-1:0] cur_floor, scan_floor;
  logic               dir_up;
  logic [FLOORS-1:0]  pending, pend_nxt, here_mask, clr;
  logic [MW-1:0]      move_cnt;
  logic [DW-1:0]      door_cnt;
  logic               above, below, here, arrive, go_up, go_down, enter_door;
  // Calls for the floor whose door is already open are dropped; decisions look at the floor the car will occupy after this edge
  always_comb begin
    here_mask  = '0;
    here_mask[cur_floor] = 1'b1;
    pend_nxt   = pending | (bus.call_req & ~(state == DOOR ? here_mask : '0));
    arrive     = (state == UP || state == DOWN) && move_cnt == MW'(MOVE_CYCLES - 1);
    scan_floor = arrive ? (state == UP ? cur_floor + FLOOR_W'(1) : cur_floor - FLOOR_W'(1)) : cur_floor;
    go_up      = dir_up ? above : (above && !below);
    go_down    = dir_up ? (below && !above) : below;
    enter_door = here && (state == IDLE || arrive);
    clr        = '0;
    clr[scan_floor] = enter_door;
  end
  req_scan #(.FLOORS(FLOORS)) u_scan (
    .pend  (pend_nxt),
    .floor (scan_floor),
    .above (above),
    .below (below),
    .here  (here)
  );
  // Controller FSM: position, direction, timers and latched calls
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cur_floor <= '0;
      dir_up    <= 1'b1;
      pending   <= '0;
      move_cnt  <= '0;
      door_cnt  <= '0;
    end else begin
      pending <= pend_nxt & ~clr;
      case (state)
        IDLE: begin
          door_cnt <= '0;
          move_cnt <= '0;
          if (here) state <= DOOR;
          else if (go_up) begin
            state  <= UP;
            dir_up <= 1'b1;
          end else if (go_down) begin
            state  <= DOWN;
            dir_up <= 1'b0;
          end
        end
        UP, DOWN: begin
          if (arrive) begin
            cur_floor <= scan_floor;
            move_cnt  <= '0;
            door_cnt  <= '0;
            if (here) state <= DOOR;
            else if (!(state == UP ? above : below)) state <= IDLE;
          end else move_cnt <= move_cnt + MW'(1);
        end
        DOOR: begin
          if (door_cnt == DW'(DOOR_CYCLES - 1)) begin
            state    <= IDLE;
            door_cnt <= '0;
          end else door_cnt <= door_cnt + DW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.state     = state;
  assign bus.floor     = cur_floor;
  assign bus.dir_up    = dir_up;
  assign bus.pending   = pending;
  assign bus.moving    = state == UP || state == DOWN;
  assign bus.door_open = state == DOOR;
endmodule

// File: tb/tb_elevator_ctrl.sv
// tb_elevator_ctrl: directed checks of SCAN service, timing, door dwell and reset
module tb_elevator_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;
  always #5 clk = ~clk;
  elevator_ctrl_if #(.FLOORS(8)) bus ();
  elevator_ctrl_if #(.FLOORS(2)) bus2 ();
  elevator_ctrl #(.FLOORS(8), .MOVE_CYCLES(4), .DOOR_CYCLES(6)) dut (.clk(clk), .rst(rst), .bus(bus));
  elevator_ctrl #(.FLOORS(2), .MOVE_CYCLES(4), .DOOR_CYCLES(6)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic car(input string tag, input logic [1:0] st, input int fl, input logic [7:0] pend);
    check({tag, ".state"}, 32'(bus.state), 32'(st));
    check({tag, ".floor"}, 32'(bus.floor), 32'(fl));
    check({tag, ".pending"}, 32'(bus.pending), 32'(pend));
  endtask
  initial begin
    bus.call_req  = '0;
    bus2.call_req = '0;
    tick(2);
    car("rst", 2'd0, 0, 8'h00);
    check("rst.dir_up", 32'(bus.dir_up), 32'd1);
    check("rst.moving", 32'(bus.moving), 32'd0);
    check("rst.door", 32'(bus.door_open), 32'd0);
    rst = 1'b0;
    bus.call_req = 8'h08;
    tick(1);
    bus.call_req = '0;
    car("t1.e1", 2'd1, 0, 8'h08);
    check("t1.e1.moving", 32'(bus.moving), 32'd1);
    tick(4); car("t1.e5", 2'd1, 1, 8'h08);
    tick(4); car("t1.e9", 2'd1, 2, 8'h08);
    tick(4); car("t1.e13", 2'd3, 3, 8'h00);
    check("t1.e13.door", 32'(bus.door_open), 32'd1);
    tick(5); car("t1.e18", 2'd3, 3, 8'h00);
    tick(1); car("t1.e19", 2'd0, 3, 8'h00);
    bus.call_req = 8'h10;
    tick(1);
    bus.call_req = '0;
    tick(4); car("t2.at4", 2'd3, 4, 8'h00);
    tick(6); car("t2.idle4", 2'd0, 4, 8'h00);
    bus.call_req = 8'h44;
    tick(1);
    bus.call_req = '0;
    car("t2.go", 2'd1, 4, 8'h44);
    check("t2.go.dir", 32'(bus.dir_up), 32'd1);
    tick(4); car("t2.f5", 2'd1, 5, 8'h44);
    tick(4); car("t2.f6", 2'd3, 6, 8'h04);
    tick(6); car("t2.idle6", 2'd0, 6, 8'h04);
    tick(1); car("t2.down", 2'd2, 6, 8'h04);
    check("t2.down.dir", 32'(bus.dir_up), 32'd0);
    tick(16); car("t2.f2", 2'd3, 2, 8'h00);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    bus.call_req = 8'h20;
    tick(1); bus.call_req = '0;
    car("t3.e1", 2'd1, 0, 8'h20);
    tick(1); bus.call_req = 8'h04;
    tick(1); bus.call_req = '0;
    car("t3.e3", 2'd1, 0, 8'h24);
    tick(6); car("t3.f2", 2'd3, 2, 8'h20);
    tick(6); car("t3.idle2", 2'd0, 2, 8'h20);
    tick(1); car("t3.resume", 2'd1, 2, 8'h20);
    tick(12); car("t3.f5", 2'd3, 5, 8'h00);
    tick(6); car("t3.idle5", 2'd0, 5, 8'h00);
    bus.call_req = 8'h20;
    tick(1); bus.call_req = '0;
    car("t4.open", 2'd3, 5, 8'h00);
    tick(1); bus.call_req = 8'h20;
    tick(3); car("t4.recall", 2'd3, 5, 8'h00);
    bus.call_req = '0;
    tick(1); car("t4.e6", 2'd3, 5, 8'h00);
    tick(1); car("t4.e7", 2'd0, 5, 8'h00);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    bus.call_req = 8'h80;
    tick(1); bus.call_req = '0;
    tick(13); car("t5.mid", 2'd1, 3, 8'h80);
    rst = 1'b1;
    bus.call_req = 8'h10;
    tick(1);
    car("t5.rst", 2'd0, 0, 8'h00);
    check("t5.rst.moving", 32'(bus.moving), 32'd0);
    check("t5.rst.door", 32'(bus.door_open), 32'd0);
    check("t5.rst.dir", 32'(bus.dir_up), 32'd1);
    rst = 1'b0;
    bus.call_req = '0;
    bus2.call_req = 2'b10;
    tick(1); bus2.call_req = '0;
    check("t6.up", 32'(bus2.state), 32'd1);
    tick(4);
    check("t6.f1.state", 32'(bus2.state), 32'd3);
    check("t6.f1.floor", 32'(bus2.floor), 32'd1);
    tick(6);
    check("t6.idle1", 32'(bus2.state), 32'd0);
    bus2.call_req = 2'b01;
    tick(1); bus2.call_req = '0;
    check("t6.down", 32'(bus2.state), 32'd2);
    check("t6.down.dir", 32'(bus2.dir_up), 32'd0);
    tick(4);
    check("t6.f0.state", 32'(bus2.state), 32'd3);
    check("t6.f0.floor", 32'(bus2.floor), 32'd0);
    tick(6);
    bus2.call_req = 2'b10;
    tick(1); bus2.call_req = '0;
    check("t6.up2", 32'(bus2.state), 32'd1);
    tick(4);
    check("t6.f1b.state", 32'(bus2.state), 32'd3);
    check("t6.f1b.floor", 32'(bus2.floor), 32'd1);
    check("t6.f1b.pending", 32'(bus2.pending), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/elevator_ctrl.md
# elevator_ctrl

Parametrised N-floor elevator controller: it latches per-floor call requests, tracks the car's floor position with a travel timer, and serves calls in SCAN order (keep direction while calls remain ahead). It holds the door open for a fixed dwell at each served floor. It supersedes the fixed three-state STOP/UP/DOWN direction FSM and sits between the floor call-button logic and the car/door drive and display outputs.

## Interface
- FLOORS, 8, number of floors (≥2); floors numbered 0..FLOORS-1
- FLOOR_W, $clog2(FLOORS), derived width of floor index
- MOVE_CYCLES, 4, clock cycles to travel one floor (≥1)
- DOOR_CYCLES, 6, clock cycles door stays open (≥1)
- clk  in  1  single clock, all state on posedge
- rst  in  1  synchronous, active-high reset
- call_req  in  FLOORS  per-floor call; any cycle high sets that floor's pending bit
- floor  out  FLOOR_W  current car floor
- dir_up  out  1  current/last travel direction (1 = up)
- moving  out  1  car travelling (state UP or DOWN)
- door_open  out  1  door open (state DOOR)
- pending  out  FLOORS  latched outstanding calls
- state  out  2  FSM state encoding

## Operation
- States: IDLE=0, UP=1, DOWN=2, DOOR=3.
- pend_nxt = pending | call_req; all decisions use pend_nxt (same-cycle calls count). Registered pending = pend_nxt minus any bit cleared this cycle.
- above = |pend_nxt[FLOORS-1:floor+1]; below = |pend_nxt[floor-1:0]; both 0 at the top or bottom floor respectively.
- IDLE: if pend_nxt[floor], go to DOOR and clear that bit. Otherwise, if dir_up, go to UP if above, else DOWN if below. If !dir_up, go to DOWN if below, else UP if above. Otherwise stay in IDLE. dir_up updates on entering UP (1) or DOWN (0).
- UP/DOWN: move_cnt counts 0..MOVE_CYCLES-1. At MOVE_CYCLES-1: floor ±1, move_cnt←0, then evaluate at the new floor f':
  - pend_nxt[f'] → DOOR, clearing bit f'.
  - Otherwise, a call still ahead → stay in the same direction.
  - Otherwise → IDLE.
- DOOR: door_cnt counts 0..DOOR_CYCLES-1, then go to IDLE. call_req for the current floor while in DOOR is discarded (never latched, timer not extended). Other floors latch normally.
- floor never leaves 0..FLOORS-1; call_req bits ≥ FLOORS do not exist.
- Simultaneous calls above and below in IDLE: dir_up decides (SCAN continuity).
- Reset (any state, including mid-travel or door open): state IDLE, floor 0, dir_up 1, pending 0, move_cnt 0, door_cnt 0; so moving 0, door_open 0. call_req in the reset cycle is ignored.

## Timing
- All outputs are registered and change only on posedge clk.
- Call to travel start: call_req high in cycle n while IDLE at a different floor → UP/DOWN at edge n+1.
- Each floor takes exactly MOVE_CYCLES cycles. Arrival and entry to DOOR happen on the same edge.
- Call at the current floor while IDLE → DOOR at the next edge.
- door_open stays high exactly DOOR_CYCLES cycles, then IDLE for at least one cycle before any new departure.
- The pending bit clears on the same edge the state enters DOOR.

## Structure
- Package elevator_pkg holds the state encoding constants (IDLE/UP/DOWN/DOOR) and the 2-bit state typedef.
- Sub-module req_scan: combinational; given pend_nxt and floor, it returns above, below and here. It is parametrised by FLOORS.
- The top module holds pending, floor, dir_up, both counters and the FSM.

## Test plan
- Reset, then call_req[3] pulse at cycle 0 with FLOORS=8, MOVE=4, DOOR=6:
  - UP at edge 1.
  - floor=1/2/3 at edges 5/9/13.
  - DOOR and pending[3]=0 at edge 13.
  - IDLE at edge 19.
- Car at floor 4, IDLE, dir_up=1, calls 2 and 6 in the same cycle → serves 6 first, then 2. dir_up=0 on departing 6.
- Moving up from 0 toward 5, call_req[2] during the first floor's travel → stops at 2 (DOOR), then continues to 5.
- Call to the current floor while IDLE → DOOR next edge, open 6 cycles. Repeated call_req at the same floor during DOOR → no extension, pending stays 0.
- rst asserted mid-travel (floor 3, UP) → next edge floor=0, IDLE, pending=0, moving=0, door_open=0.
- FLOORS=2 build: calls 1 then 0 alternate. floor stays within 0..1 and never wraps.
